// File: rtl/mips_pkg.sv
// Shared widths, reset PC and the {pc, inst} entry type for the fetch stage.
// Pure type/constant package; no logic, no latency.
package mips_pkg;

  localparam int INST_W = 32;
  localparam int ADDR_W = 32;
  localparam logic [ADDR_W-1:0] PC_STEP = 32'd4;
  localparam logic [ADDR_W-1:0] DEFAULT_RESET_PC = 32'h0000_0000;

  typedef struct packed {
    logic [ADDR_W-1:0] pc;
    logic [INST_W-1:0] inst;
  } fetch_entry_t;

  function automatic logic [ADDR_W-1:0] word_align(input logic [ADDR_W-1:0] addr);
    return {addr[ADDR_W-1:2], 2'b00};
  endfunction

endpackage

// File: rtl/fetch_queue.sv
// Synchronous FIFO of {pc, inst}; head presented straight from storage registers, push visible next cycle.
// Flush wins over push/pop; pushes when full and pops when empty are ignored (caller owns flow control).
module fetch_queue
  import mips_pkg::*;
#(
  parameter int DEPTH = 4,
  localparam int PW = $clog2(DEPTH),
  localparam int CW = $clog2(DEPTH + 1)
) (
  input  logic         clock,
  input  logic         reset_n,
  input  logic         push,
  input  fetch_entry_t push_dat,
  input  logic         pop,
  input  logic         flush,
  output fetch_entry_t head,
  output logic         head_vld,
  output logic [CW-1:0] count
);

  fetch_entry_t   mem [DEPTH];
  logic [PW-1:0]  rd_ptr;
  logic [PW-1:0]  wr_ptr;
  logic           do_push;
  logic           do_pop;

  assign do_push  = push & ~flush & (count != CW'(DEPTH));
  assign do_pop   = pop & ~flush & (count != '0);
  assign head     = mem[rd_ptr];
  assign head_vld = (count != '0);

  // Storage is cleared on reset so the head reads as zero out of reset.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else if (flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= push_dat;
        wr_ptr      <= wr_ptr + PW'(1);
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + PW'(1);
      end
      case ({do_push, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch: in-order requests to variable-latency imem, words queued with their PCs for decode.
// Response to inst_valid is one cycle; requests stall when queued + outstanding reaches QDEPTH.
module fetch_unit
  import mips_pkg::*;
#(
  parameter int QDEPTH = 4,
  parameter logic [ADDR_W-1:0] RESET_PC = DEFAULT_RESET_PC
) (
  input  logic              clock,
  input  logic              reset_n,
  output logic              imem_req,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic              imem_ready,
  input  logic              imem_rvalid,
  input  logic [INST_W-1:0] imem_rdata,
  input  logic              redirect_valid,
  input  logic [ADDR_W-1:0] redirect_pc,
  output logic              inst_valid,
  output logic [INST_W-1:0] inst,
  output logic [ADDR_W-1:0] inst_pc,
  input  logic              inst_ready
);

  localparam int CW = $clog2(QDEPTH + 1);

  logic [ADDR_W-1:0] fetch_pc;
  logic [ADDR_W-1:0] resp_pc;
  logic [ADDR_W-1:0] target_pc;
  logic [CW-1:0]     outstanding;
  logic [CW-1:0]     outstanding_nxt;
  logic [CW-1:0]     drop;
  logic [CW-1:0]     occupancy;
  logic [CW:0]       inflight;
  logic              credit_ok;
  logic              accept;
  logic              resp;
  logic              resp_drop;
  logic              enq;
  logic              deq;
  fetch_entry_t      push_dat;
  fetch_entry_t      head;

  assign inflight  = {1'b0, occupancy} + {1'b0, outstanding};
  assign credit_ok = (inflight < (CW+1)'(QDEPTH));
  assign imem_req  = reset_n & ~redirect_valid & credit_ok;
  assign imem_addr = fetch_pc;
  assign target_pc = word_align(redirect_pc);

  assign accept    = imem_req & imem_ready;
  // An rvalid with nothing outstanding is a protocol error and is ignored.
  assign resp      = imem_rvalid & (outstanding != '0);
  assign resp_drop = resp & (drop != '0);
  assign enq       = resp & ~resp_drop & ~redirect_valid;
  assign deq       = inst_valid & inst_ready;
  assign push_dat  = '{pc: resp_pc, inst: imem_rdata};

  always_comb begin
    outstanding_nxt = outstanding;
    if (accept && !resp) begin
      outstanding_nxt = outstanding + CW'(1);
    end else if (!accept && resp) begin
      outstanding_nxt = outstanding - CW'(1);
    end
  end

  // On redirect everything still in flight after this cycle becomes stale and must be discarded.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      fetch_pc    <= RESET_PC;
      resp_pc     <= RESET_PC;
      outstanding <= '0;
      drop        <= '0;
    end else begin
      outstanding <= outstanding_nxt;
      if (redirect_valid) begin
        fetch_pc <= target_pc;
        resp_pc  <= target_pc;
        drop     <= outstanding_nxt;
      end else begin
        if (accept) begin
          fetch_pc <= fetch_pc + PC_STEP;
        end
        if (enq) begin
          resp_pc <= resp_pc + PC_STEP;
        end
        if (resp_drop) begin
          drop <= drop - CW'(1);
        end
      end
    end
  end

  fetch_queue #(
    .DEPTH (QDEPTH)
  ) u_queue (
    .clock    (clock),
    .reset_n  (reset_n),
    .push     (enq),
    .push_dat (push_dat),
    .pop      (deq),
    .flush    (redirect_valid),
    .head     (head),
    .head_vld (inst_valid),
    .count    (occupancy)
  );

  assign inst    = head.inst;
  assign inst_pc = head.pc;

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: behavioural imem with programmable latency plus an in-order {pc, inst} scoreboard.
module tb_fetch_unit;

  logic        clock = 1'b0;
  logic        reset_n;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        inst_valid;
  logic [31:0] inst;
  logic [31:0] inst_pc;
  logic        inst_ready;

  always #5 clock = ~clock;

  fetch_unit #(.QDEPTH(4), .RESET_PC(32'h0000_0000)) dut (
    .clock          (clock),
    .reset_n        (reset_n),
    .imem_req       (imem_req),
    .imem_addr      (imem_addr),
    .imem_ready     (imem_ready),
    .imem_rvalid    (imem_rvalid),
    .imem_rdata     (imem_rdata),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .inst_valid     (inst_valid),
    .inst           (inst),
    .inst_pc        (inst_pc),
    .inst_ready     (inst_ready)
  );

  typedef struct {
    logic [31:0] addr;
    int          due;
  } pend_t;

  typedef struct {
    logic [31:0] rpc;
    logic [31:0] a0;
    logic [31:0] a1;
  } redir_vec_t;

  int          tests = 0;
  int          fails = 0;
  int          cyc = 0;
  int          lat = 1;
  int          rel;
  int          n0;
  pend_t       pend[$];
  logic [31:0] exp_pc[$];
  int          cons_cyc[$];
  logic [31:0] req_addr[$];
  redir_vec_t  vt[4];

  function automatic logic [31:0] memword(input logic [31:0] a);
    case (a)
      32'h0000_0000: return 32'h2009_000f;
      32'h0000_0004: return 32'h200a_0007;
      32'h0000_0008: return 32'h012a_5824;
      default:       return a ^ 32'hdead_beef;
    endcase
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got %h, required %h", name, act, req);
    end
  endtask

  task automatic tick();
    @(negedge clock);
    #1;
  endtask

  task automatic push_seq(input logic [31:0] start, input int n);
    for (int i = 0; i < n; i++) exp_pc.push_back(start + 32'(4 * i));
  endtask

  task automatic wait_cons(input int n, input int budget, input string name);
    for (int i = 0; i < budget && cons_cyc.size() < n; i++) tick();
    check(name, 32'(cons_cyc.size() >= n), 32'd1);
  endtask

  task automatic clear_books();
    pend.delete();
    exp_pc.delete();
    cons_cyc.delete();
    req_addr.delete();
  endtask

  task automatic do_reset(input int lat_i, input logic ir, output int rel_cyc);
    tick();
    reset_n = 1'b0;
    clear_books();
    lat = lat_i;
    inst_ready = ir;
    imem_ready = 1'b1;
    redirect_valid = 1'b0;
    tick();
    tick();
    reset_n = 1'b1;
    rel_cyc = cyc;
  endtask

  // Memory model drives responses at negedge; monitor/scoreboard samples settled values at negedge+3.
  initial begin
    imem_rvalid = 1'b0;
    imem_rdata  = '0;
    forever begin
      @(negedge clock);
      cyc++;
      if (pend.size() > 0 && pend[0].due <= cyc) begin
        imem_rvalid = 1'b1;
        imem_rdata  = memword(pend[0].addr);
        pend.delete(0);
      end else begin
        imem_rvalid = 1'b0;
        imem_rdata  = '0;
      end
      #3;
      if (reset_n && inst_valid && inst_ready && !redirect_valid) begin
        cons_cyc.push_back(cyc);
        if (exp_pc.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL sb_unexpected: got pc %h, no instruction required", inst_pc);
        end else begin
          logic [31:0] e;
          e = exp_pc.pop_front();
          check("sb_pc", inst_pc, e);
          check("sb_inst", inst, memword(e));
        end
      end
      if (imem_req && imem_ready) begin
        req_addr.push_back(imem_addr);
        pend.push_back('{addr: imem_addr, due: cyc + lat});
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, limit 100000 ns required");
    fails++;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $fatal(1, "watchdog");
  end

  initial begin
    vt[0] = '{rpc: 32'hFFFF_FFFE, a0: 32'hFFFF_FFFC, a1: 32'h0000_0000};
    vt[1] = '{rpc: 32'h0000_0040, a0: 32'h0000_0040, a1: 32'h0000_0044};
    vt[2] = '{rpc: 32'h0000_0123, a0: 32'h0000_0120, a1: 32'h0000_0124};
    vt[3] = '{rpc: 32'h7FFF_FFFD, a0: 32'h7FFF_FFFC, a1: 32'h8000_0000};

    reset_n = 1'b0;
    imem_ready = 1'b1;
    redirect_valid = 1'b0;
    redirect_pc = '0;
    inst_ready = 1'b0;
    repeat (3) tick();
    check("rst_req", 32'(imem_req), 32'd0);
    check("rst_addr", imem_addr, 32'h0);
    check("rst_valid", 32'(inst_valid), 32'd0);
    check("rst_inst", inst, 32'h0);
    check("rst_pc", inst_pc, 32'h0);

    // Streaming with 1-cycle memory: one instruction per cycle, first two cycles after release.
    do_reset(1, 1'b1, rel);
    push_seq(32'h0, 40);
    wait_cons(3, 20, "t1_stream");
    if (cons_cyc.size() >= 3) begin
      check("t1_cyc0", 32'(cons_cyc[0]), 32'(rel + 2));
      check("t1_cyc1", 32'(cons_cyc[1]), 32'(rel + 3));
      check("t1_cyc2", 32'(cons_cyc[2]), 32'(rel + 4));
    end

    // Decode stalled: credit stops requests at QDEPTH, then drains and resumes at 0x10.
    do_reset(1, 1'b0, rel);
    push_seq(32'h0, 40);
    repeat (10) tick();
    check("t2_req_cnt", 32'(req_addr.size()), 32'd4);
    for (int i = 0; i < 4 && i < req_addr.size(); i++)
      check($sformatf("t2_addr%0d", i), req_addr[i], 32'(4 * i));
    check("t2_req_low", 32'(imem_req), 32'd0);
    check("t2_valid", 32'(inst_valid), 32'd1);
    check("t2_head_pc", inst_pc, 32'h0);
    inst_ready = 1'b1;
    wait_cons(8, 20, "t2_drain");
    if (req_addr.size() > 4) check("t2_resume", req_addr[4], 32'h10);

    // 3-cycle memory, two outstanding, redirect before either returns.
    do_reset(3, 1'b1, rel);
    tick();
    tick();
    imem_ready = 1'b0;
    redirect_valid = 1'b1;
    redirect_pc = 32'h40;
    exp_pc.delete();
    push_seq(32'h40, 20);
    #1;
    check("t3_setup_reqs", 32'(req_addr.size()), 32'd2);
    check("t3_req_redirect", 32'(imem_req), 32'd0);
    tick();
    redirect_valid = 1'b0;
    imem_ready = 1'b1;
    #1;
    check("t3_valid_after", 32'(inst_valid), 32'd0);
    check("t3_addr_after", imem_addr, 32'h40);
    check("t3_req_after", 32'(imem_req), 32'd1);
    wait_cons(2, 30, "t3_target");

    // Redirect coinciding with a response and a dequeue.
    do_reset(1, 1'b1, rel);
    push_seq(32'h0, 40);
    repeat (5) tick();
    check("t4_pre_rvalid", 32'(imem_rvalid), 32'd1);
    check("t4_pre_valid", 32'(inst_valid), 32'd1);
    redirect_valid = 1'b1;
    redirect_pc = 32'h200;
    exp_pc.delete();
    push_seq(32'h200, 20);
    n0 = cons_cyc.size();
    tick();
    redirect_valid = 1'b0;
    #1;
    check("t4_valid_after", 32'(inst_valid), 32'd0);
    check("t4_addr_after", imem_addr, 32'h200);
    check("t4_req_after", 32'(imem_req), 32'd1);
    wait_cons(n0 + 3, 20, "t4_target");

    // Table of redirect targets: alignment and address wrap.
    do_reset(1, 1'b1, rel);
    push_seq(32'h0, 40);
    repeat (3) tick();
    for (int i = 0; i < 4; i++) begin
      redirect_valid = 1'b1;
      redirect_pc = vt[i].rpc;
      exp_pc.delete();
      push_seq(vt[i].a0, 30);
      #1;
      check($sformatf("t5_req_redir%0d", i), 32'(imem_req), 32'd0);
      tick();
      redirect_valid = 1'b0;
      #1;
      check($sformatf("t5_addr0_%0d", i), imem_addr, vt[i].a0);
      check($sformatf("t5_req_%0d", i), 32'(imem_req), 32'd1);
      tick();
      check($sformatf("t5_addr1_%0d", i), imem_addr, vt[i].a1);
      n0 = cons_cyc.size();
      wait_cons(n0 + 2, 20, $sformatf("t5_cons%0d", i));
    end

    // One-cycle reset mid-transfer with two queued and two outstanding.
    do_reset(3, 1'b0, rel);
    push_seq(32'h0, 40);
    repeat (5) tick();
    check("t6_setup_reqs", 32'(req_addr.size()), 32'd4);
    check("t6_setup_valid", 32'(inst_valid), 32'd1);
    reset_n = 1'b0;
    clear_books();
    lat = 1;
    tick();
    check("t6_rst_req", 32'(imem_req), 32'd0);
    check("t6_rst_addr", imem_addr, 32'h0);
    check("t6_rst_valid", 32'(inst_valid), 32'd0);
    check("t6_rst_inst", inst, 32'h0);
    check("t6_rst_pc", inst_pc, 32'h0);
    reset_n = 1'b1;
    inst_ready = 1'b1;
    rel = cyc;
    push_seq(32'h0, 20);
    wait_cons(3, 20, "t6_refetch");
    if (cons_cyc.size() >= 1) check("t6_first_cyc", 32'(cons_cyc[0]), 32'(rel + 2));

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
